mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Request arbiter and sequencer in front of the byte-serial memory controller. Accepts independent requests from the LSB (load/store) and the ICache (instruction fetch), grants exactly one at a time to the controller's request port, and routes the controller's completion strobe and data back to the granted requester. Handles pipeline `clear` (flush) without corrupting an in-flight store, and enforces the one-idle-cycle gap the controller needs between transactions.

## Interface
- `MAX_LSB_STREAK`, 4: consecutive LSB grants allowed while an ICache request waits (1..15); used only with the starvation guard.
- `clk_in` in 1: clock, rising edge.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global enable; low freezes all state and outputs.
- `clear` in 1: pipeline flush.
- `lsb_req` in 1: LSB request level, held until `lsb_done`.
- `lsb_we` in 1: 1 = store, 0 = load.
- `lsb_addr` in 32: byte address.
- `lsb_wdata` in 32: store data, little-endian.
- `lsb_len` in 4: access length in bytes: 1, 2 or 4.
- `lsb_done` out 1: one-cycle completion pulse.
- `lsb_rdata` out 32: load data, valid with `lsb_done`.
- `ic_req` in 1: ICache fetch request level, held until `ic_done`.
- `ic_addr` in 32: fetch address.
- `ic_done` out 1: one-cycle completion pulse.
- `ic_rdata` out 32: instruction word, valid with `ic_done`.
- `mc_w_en`, `mc_r_en`, `mc_ic_en` out 1 each: controller request enables.
- `mc_addr` out 32, `mc_wdata` out 32, `mc_len` out 4, `mc_ic_addr` out 32: controller request fields.
- `mc_lsb_done` in 1, `mc_lsb_data` in 32: controller data-side completion.
- `mc_ic_done` in 1, `mc_ic_data` in 32: controller fetch completion.

## Operation
- States: `IDLE`, `BUSY_LSB`, `BUSY_IC`, `GAP`.
- `IDLE`: pick a winner from the requests sampled this edge. The LSB wins by default. With the guard enabled, the ICache wins when `ic_req` is high and `streak == MAX_LSB_STREAK`. On a grant, register the request fields and the matching enable(s), then move to `BUSY_*`.
- `BUSY_LSB`: hold `mc_w_en` (store) or `mc_r_en` (load) together with the address, data and length fields. On `mc_lsb_done`:
  - pulse `lsb_done`;
  - `lsb_rdata <= mc_lsb_data`;
  - drop all enables;
  - go to `GAP`.
- `BUSY_IC`: behaves the same way, using `mc_ic_en`, `mc_ic_done`, `ic_done` and `ic_rdata`.
- `GAP`: exactly one cycle with all enables low, then `IDLE`. Neither requester can be granted here.
- `clear` (edge at which it is sampled high):
  - `IDLE`, `GAP`, `BUSY_IC`, or `BUSY_LSB` with a load: drop enables, suppress the done pulse, go to `GAP`.
  - `BUSY_LSB` with a store: ignored. The store completes normally and `lsb_done` is still pulsed.
- A done strobe from the controller that does not match the current state is ignored.
- `streak` (4 bits) resets to 0 on an ICache grant, and also whenever `ic_req` is low at a grant. It increments on an LSB grant while `ic_req` is high, saturating at `MAX_LSB_STREAK`.

## Timing
- Reset values: state `IDLE`; every `mc_*` enable 0; `mc_addr`, `mc_wdata`, `mc_ic_addr`, `mc_len` 0; `lsb_done`, `ic_done` 0; `lsb_rdata`, `ic_rdata` 0; `streak` 0.
- All outputs are registered.
- A request sampled in `IDLE` at edge N drives the `mc_*` enables from N+1.
- `mc_*_done` sampled at edge M produces the requester's done pulse during M+1 → M+2.
- The earliest next grant is at edge M+2; its enables are visible from M+3.
- Added overhead per transaction: 1 cycle of request latency plus 1 cycle of `GAP`.
- Simultaneous `clear` and `mc_lsb_done` on a load: `clear` wins and no done is pulsed.
- Simultaneous `clear` and `mc_lsb_done` on a store: the done is pulsed.
- `rdy_in` low: no state, counter or output changes. Done pulses stretch accordingly.
- Reset mid-transaction: asynchronous return to the reset values. The controller is reset by the same `rst_in`.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: the streak counter and ICache forced-grant rule are built in.
- Not defined: strict LSB-over-ICache priority. `streak` and `MAX_LSB_STREAK` are unused and the logic is removed.

## Structure
- Shared definitions in `def.v`:
  - the state encodings `ARB_Idle`, `ARB_Busy_LSB`, `ARB_Busy_IC`, `ARB_Gap`;
  - the existing `InstSize` width macro, used for all 32-bit buses.
- One sub-module, `arb_streak_counter`: the saturating counter plus the force-ICache compare, instantiated only under `ARB_STARVE_GUARD_EN`.

## Test plan
- Single load: `lsb_req=1`, `lsb_we=0`, addr 0x100, len 4; controller done with data 0xDEADBEEF → `mc_r_en` high from N+1, `lsb_rdata=0xDEADBEEF`, `lsb_done` high for exactly 1 cycle.
- Simultaneous requests: LSB store and ICache fetch at 0x0 raised together → store granted first; then one `GAP` cycle; then `mc_ic_en` with `mc_ic_addr=0`.
- Starvation (guard on, `MAX_LSB_STREAK=4`): `lsb_req` held continuously, `ic_req` high → after 4 LSB grants the 5th grant goes to the ICache, then `streak` reads 0.
- Clear on a load: `clear` pulsed 2 cycles into `BUSY_LSB` (load) → enables drop next cycle, no `lsb_done`, `GAP`, then `IDLE`.
- Clear on a store: `clear` pulsed during a store, with `mc_lsb_done` in the same cycle → `lsb_done` still pulses and the store is not re-issued.
- `rdy_in` low for 3 cycles mid-fetch, with `mc_ic_done` asserted after `rdy_in` returns → state held during the stall, then `ic_done` pulses once with the correct `ic_rdata`.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the memory request arbiter: state encodings and bus widths.
package mem_req_arbiter_pkg;

    localparam int unsigned InstSize = 32;
    localparam int unsigned LenW     = 4;
    localparam int unsigned StreakW  = 4;

    typedef enum logic [1:0] {
        ARB_Idle     = 2'd0,
        ARB_Busy_LSB = 2'd1,
        ARB_Busy_IC  = 2'd2,
        ARB_Gap      = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester and controller-side signals of the arbiter.
// The master modport is the arbiter; the slave modport is the surrounding environment.
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic                lsb_req;
    logic                lsb_we;
    logic [InstSize-1:0] lsb_addr;
    logic [InstSize-1:0] lsb_wdata;
    logic [LenW-1:0]     lsb_len;
    logic                lsb_done;
    logic [InstSize-1:0] lsb_rdata;

    logic                ic_req;
    logic [InstSize-1:0] ic_addr;
    logic                ic_done;
    logic [InstSize-1:0] ic_rdata;

    logic                mc_w_en;
    logic                mc_r_en;
    logic                mc_ic_en;
    logic [InstSize-1:0] mc_addr;
    logic [InstSize-1:0] mc_wdata;
    logic [LenW-1:0]     mc_len;
    logic [InstSize-1:0] mc_ic_addr;
    logic                mc_lsb_done;
    logic [InstSize-1:0] mc_lsb_data;
    logic                mc_ic_done;
    logic [InstSize-1:0] mc_ic_data;

    modport master (
        input  lsb_req, lsb_we, lsb_addr, lsb_wdata, lsb_len,
        input  ic_req, ic_addr,
        input  mc_lsb_done, mc_lsb_data, mc_ic_done, mc_ic_data,
        output lsb_done, lsb_rdata, ic_done, ic_rdata,
        output mc_w_en, mc_r_en, mc_ic_en, mc_addr, mc_wdata, mc_len, mc_ic_addr
    );

    modport slave (
        output lsb_req, lsb_we, lsb_addr, lsb_wdata, lsb_len,
        output ic_req, ic_addr,
        output mc_lsb_done, mc_lsb_data, mc_ic_done, mc_ic_data,
        input  lsb_done, lsb_rdata, ic_done, ic_rdata,
        input  mc_w_en, mc_r_en, mc_ic_en, mc_addr, mc_wdata, mc_len, mc_ic_addr
    );

endinterface

// File: rtl/mem_req_arbiter_streak_counter.sv
// Saturating count of consecutive LSB grants taken while the ICache waits,
// plus the compare that forces the next grant to the ICache.
// Only built when ARB_STARVE_GUARD_EN is defined.
`ifdef ARB_STARVE_GUARD_EN
module arb_streak_counter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LSB_STREAK = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               grant_lsb,
    input  logic               grant_ic,
    input  logic               ic_req,
    output logic [StreakW-1:0] streak,
    output logic               force_ic_c
);

    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_LSB_STREAK);

    // Force the ICache once the LSB has used up its streak allowance.
    assign force_ic_c = ic_req && (streak == StreakMax);

    // Count LSB grants that overtook a waiting fetch; any other grant restarts the streak.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            streak <= '0;
        end else if (grant_ic || (grant_lsb && !ic_req)) begin
            streak <= '0;
        end else if (grant_lsb && (streak != StreakMax)) begin
            streak <= streak + StreakW'(1);
        end
    end

endmodule
`endif

// File: rtl/mem_req_arbiter.sv
// Arbiter/sequencer between the LSB, the ICache and the byte-serial memory controller.
// One transaction at a time, a mandatory idle GAP cycle between transactions, and a
// flush (clear) that never aborts an in-flight store.
// Optional feature macro: ARB_STARVE_GUARD_EN (bounded LSB streak while a fetch waits).
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int unsigned MAX_LSB_STREAK = 4
)
`endif
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    mem_req_arbiter_if.master bus
);

    arb_state_e state;
    logic       idle_go_c;
    logic       grant_lsb_c;
    logic       grant_ic_c;
    logic       force_ic_c;

    // Grant decision for this edge; the LSB wins unless the fetch is being forced.
    assign idle_go_c   = rdy_in && (state == ARB_Idle) && !clear;
    assign grant_ic_c  = idle_go_c && bus.ic_req && (force_ic_c || !bus.lsb_req);
    assign grant_lsb_c = idle_go_c && bus.lsb_req && !grant_ic_c;

`ifdef ARB_STARVE_GUARD_EN
    logic [StreakW-1:0] streak;

    arb_streak_counter #(
        .MAX_LSB_STREAK(MAX_LSB_STREAK)
    ) u_streak (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .grant_lsb  (grant_lsb_c),
        .grant_ic   (grant_ic_c),
        .ic_req     (bus.ic_req),
        .streak     (streak),
        .force_ic_c (force_ic_c)
    );
`else
    assign force_ic_c = 1'b0;
`endif

    // Sequencer: state, controller request fields and requester completions.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= ARB_Idle;
            bus.mc_w_en    <= 1'b0;
            bus.mc_r_en    <= 1'b0;
            bus.mc_ic_en   <= 1'b0;
            bus.mc_addr    <= '0;
            bus.mc_wdata   <= '0;
            bus.mc_len     <= '0;
            bus.mc_ic_addr <= '0;
            bus.lsb_done   <= 1'b0;
            bus.lsb_rdata  <= '0;
            bus.ic_done    <= 1'b0;
            bus.ic_rdata   <= '0;
        end else if (rdy_in) begin
            bus.lsb_done <= 1'b0;
            bus.ic_done  <= 1'b0;
            case (state)
                ARB_Idle: begin
                    if (grant_lsb_c) begin
                        bus.mc_w_en  <= bus.lsb_we;
                        bus.mc_r_en  <= ~bus.lsb_we;
                        bus.mc_addr  <= bus.lsb_addr;
                        bus.mc_wdata <= bus.lsb_wdata;
                        bus.mc_len   <= bus.lsb_len;
                        state        <= ARB_Busy_LSB;
                    end else if (grant_ic_c) begin
                        bus.mc_ic_en   <= 1'b1;
                        bus.mc_ic_addr <= bus.ic_addr;
                        state          <= ARB_Busy_IC;
                    end else if (clear) begin
                        state <= ARB_Gap;
                    end
                end
                ARB_Busy_LSB: begin
                    // A store in flight is never flushed; a load is.
                    if (bus.mc_lsb_done && (bus.mc_w_en || !clear)) begin
                        bus.lsb_done  <= 1'b1;
                        bus.lsb_rdata <= bus.mc_lsb_data;
                        bus.mc_w_en   <= 1'b0;
                        bus.mc_r_en   <= 1'b0;
                        state         <= ARB_Gap;
                    end else if (clear && !bus.mc_w_en) begin
                        bus.mc_r_en <= 1'b0;
                        state       <= ARB_Gap;
                    end
                end
                ARB_Busy_IC: begin
                    if (clear) begin
                        bus.mc_ic_en <= 1'b0;
                        state        <= ARB_Gap;
                    end else if (bus.mc_ic_done) begin
                        bus.ic_done  <= 1'b1;
                        bus.ic_rdata <= bus.mc_ic_data;
                        bus.mc_ic_en <= 1'b0;
                        state        <= ARB_Gap;
                    end
                end
                ARB_Gap: begin
                    state <= clear ? ARB_Gap : ARB_Idle;
                end
                default: begin
                    state <= ARB_Idle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a vector table for basic traffic plus
// hand-written sequences for flush, stall, reset and streak behaviour.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;

    mem_req_arbiter_if bus();

    mem_req_arbiter dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .clear  (clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        lreq;
        logic        lwe;
        logic [3:0]  llen;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic        ireq;
        logic [31:0] iaddr;
        logic        mld;
        logic [31:0] mldata;
        logic        mid;
        logic [31:0] midata;
        logic        ew;
        logic        er;
        logic        ei;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  elen;
        logic [31:0] eicaddr;
        logic        eld;
        logic [31:0] elrdata;
        logic        eid;
        logic [31:0] eirdata;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl[NV];

    function automatic logic [168:0] obs();
        return {bus.mc_w_en, bus.mc_r_en, bus.mc_ic_en, bus.mc_addr, bus.mc_wdata, bus.mc_len,
                bus.mc_ic_addr, bus.lsb_done, bus.lsb_rdata, bus.ic_done, bus.ic_rdata};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string nm, input logic [168:0] act, input logic [168:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rdy             = 1'b1;
        clear           = 1'b0;
        bus.lsb_req     = 1'b0;
        bus.lsb_we      = 1'b0;
        bus.lsb_addr    = 32'h0;
        bus.lsb_wdata   = 32'h0;
        bus.lsb_len     = 4'd0;
        bus.ic_req      = 1'b0;
        bus.ic_addr     = 32'h0;
        bus.mc_lsb_done = 1'b0;
        bus.mc_lsb_data = 32'h0;
        bus.mc_ic_done  = 1'b0;
        bus.mc_ic_data  = 32'h0;
    endtask

    int  grants[$];
    int  exp_g;
    logic seen_ic;

    initial begin
        // name, lreq lwe llen laddr lwdata, ireq iaddr, mld mldata, mid midata |
        // ew er ei, addr wdata len icaddr, lsb_done lsb_rdata, ic_done ic_rdata
        tbl[0]  = '{"load_grant", 1'b1, 1'b0, 4'd4, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'd4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[1]  = '{"load_stray_ic_done", 1'b1, 1'b0, 4'd4, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h12345678,
                    1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'd4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2]  = '{"load_done", 1'b1, 1'b0, 4'd4, 32'h100, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 4'd4, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[3]  = '{"load_gap_pulse_end", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 4'd4, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[4]  = '{"idle_stray_strobes", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h99999999, 1'b1, 32'h77777777,
                    1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 4'd4, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[5]  = '{"simul_store_first", 1'b1, 1'b1, 4'd4, 32'h200, 32'h11223344, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b1, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[6]  = '{"store_done", 1'b1, 1'b1, 4'd4, 32'h200, 32'h11223344, 1'b1, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[7]  = '{"gap_blocks_ic", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[8]  = '{"ic_grant_addr0", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[9]  = '{"ic_done", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1, 32'h13579BDF,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 32'h13579BDF};
        tbl[10] = '{"ic_gap_pulse_end", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 32'h13579BDF};
        tbl[11] = '{"ic_grant_addr40", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b1, 32'h200, 32'h11223344, 4'd4, 32'h40, 1'b0, 32'hCAFEF00D, 1'b0, 32'h13579BDF};
        tbl[12] = '{"ic_done_40", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'hA5A5A5A5,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h40, 1'b0, 32'hCAFEF00D, 1'b1, 32'hA5A5A5A5};
        tbl[13] = '{"ic_gap_40", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h200, 32'h11223344, 4'd4, 32'h40, 1'b0, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5};
        tbl[14] = '{"half_load_grant", 1'b1, 1'b0, 4'd2, 32'h103, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b1, 1'b0, 32'h103, 32'hFFFFFFFF, 4'd2, 32'h40, 1'b0, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5};
        tbl[15] = '{"half_load_done", 1'b1, 1'b0, 4'd2, 32'h103, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 32'h0000BEEF, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h103, 32'hFFFFFFFF, 4'd2, 32'h40, 1'b1, 32'h0000BEEF, 1'b0, 32'hA5A5A5A5};
        tbl[16] = '{"half_load_gap", 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 1'b0, 32'h103, 32'hFFFFFFFF, 4'd2, 32'h40, 1'b0, 32'h0000BEEF, 1'b0, 32'hA5A5A5A5};

        // Reset values
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk_v("reset_outputs", obs(), '0);
        chk_w("reset_state", 32'(dut.state), 32'(ARB_Idle));
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < NV; i++) begin
            bus.lsb_req     = tbl[i].lreq;
            bus.lsb_we      = tbl[i].lwe;
            bus.lsb_len     = tbl[i].llen;
            bus.lsb_addr    = tbl[i].laddr;
            bus.lsb_wdata   = tbl[i].lwdata;
            bus.ic_req      = tbl[i].ireq;
            bus.ic_addr     = tbl[i].iaddr;
            bus.mc_lsb_done = tbl[i].mld;
            bus.mc_lsb_data = tbl[i].mldata;
            bus.mc_ic_done  = tbl[i].mid;
            bus.mc_ic_data  = tbl[i].midata;
            step();
            chk_v(tbl[i].name, obs(),
                  {tbl[i].ew, tbl[i].er, tbl[i].ei, tbl[i].eaddr, tbl[i].ewdata, tbl[i].elen,
                   tbl[i].eicaddr, tbl[i].eld, tbl[i].elrdata, tbl[i].eid, tbl[i].eirdata});
        end

        // Clear two cycles into a load
        idle_inputs();
        bus.lsb_req  = 1'b1;
        bus.lsb_addr = 32'h300;
        bus.lsb_len  = 4'd4;
        step();
        chk_b("clr_load_grant", bus.mc_r_en, 1'b1);
        step();
        chk_b("clr_load_busy", bus.mc_r_en, 1'b1);
        clear       = 1'b1;
        bus.lsb_req = 1'b0;
        step();
        chk_v("clr_load_drop", {bus.mc_r_en, bus.lsb_done, 167'(0)}, '0);
        chk_w("clr_load_gap", 32'(dut.state), 32'(ARB_Gap));
        clear = 1'b0;
        step();
        chk_w("clr_load_idle", 32'(dut.state), 32'(ARB_Idle));
        chk_b("clr_load_no_done", bus.lsb_done, 1'b0);

        // Clear together with the load completion: clear wins
        bus.lsb_req  = 1'b1;
        bus.lsb_addr = 32'h304;
        step();
        chk_b("clr_done_load_grant", bus.mc_r_en, 1'b1);
        clear           = 1'b1;
        bus.mc_lsb_done = 1'b1;
        bus.mc_lsb_data = 32'h11111111;
        bus.lsb_req     = 1'b0;
        step();
        chk_b("clr_done_load_no_done", bus.lsb_done, 1'b0);
        chk_w("clr_done_load_rdata_kept", bus.lsb_rdata, 32'h0000BEEF);
        chk_b("clr_done_load_en", bus.mc_r_en, 1'b0);
        idle_inputs();
        step();

        // Clear during a store is ignored; the store still completes once
        bus.lsb_req   = 1'b1;
        bus.lsb_we    = 1'b1;
        bus.lsb_addr  = 32'h400;
        bus.lsb_wdata = 32'h55AA55AA;
        bus.lsb_len   = 4'd4;
        step();
        chk_b("clr_store_grant", bus.mc_w_en, 1'b1);
        clear = 1'b1;
        step();
        chk_b("clr_store_held", bus.mc_w_en, 1'b1);
        chk_w("clr_store_state", 32'(dut.state), 32'(ARB_Busy_LSB));
        bus.mc_lsb_done = 1'b1;
        step();
        chk_b("clr_store_done", bus.lsb_done, 1'b1);
        chk_b("clr_store_en_drop", bus.mc_w_en, 1'b0);
        idle_inputs();
        step();
        chk_w("clr_store_idle", 32'(dut.state), 32'(ARB_Idle));
        chk_b("clr_store_pulse_end", bus.lsb_done, 1'b0);
        step();
        chk_b("clr_store_not_reissued", bus.mc_w_en, 1'b0);

        // rdy_in stall during a fetch, then a stretched done pulse
        bus.ic_req  = 1'b1;
        bus.ic_addr = 32'h80;
        step();
        chk_b("stall_ic_grant", bus.mc_ic_en, 1'b1);
        chk_w("stall_ic_addr", bus.mc_ic_addr, 32'h80);
        rdy   = 1'b0;
        clear = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_b("stall_ic_en_held", bus.mc_ic_en, 1'b1);
            chk_w("stall_state_held", 32'(dut.state), 32'(ARB_Busy_IC));
        end
        rdy            = 1'b1;
        clear          = 1'b0;
        bus.mc_ic_done = 1'b1;
        bus.mc_ic_data = 32'h0BADF00D;
        step();
        chk_v("stall_ic_done", {bus.mc_ic_en, bus.ic_done, bus.ic_rdata, 135'(0)},
              {1'b0, 1'b1, 32'h0BADF00D, 135'(0)});
        rdy            = 1'b0;
        bus.mc_ic_done = 1'b0;
        bus.ic_req     = 1'b0;
        step();
        chk_b("stall_done_stretch", bus.ic_done, 1'b1);
        rdy = 1'b1;
        step();
        chk_b("stall_done_end", bus.ic_done, 1'b0);
        chk_w("stall_idle", 32'(dut.state), 32'(ARB_Idle));

        // Asynchronous reset in the middle of a store
        bus.lsb_req   = 1'b1;
        bus.lsb_we    = 1'b1;
        bus.lsb_addr  = 32'h500;
        bus.lsb_wdata = 32'h12345678;
        bus.lsb_len   = 4'd1;
        step();
        chk_w("rst_mid_len", 32'(bus.mc_len), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_v("rst_mid_outputs", obs(), '0);
        chk_w("rst_mid_state", 32'(dut.state), 32'(ARB_Idle));
        idle_inputs();
        step();
        rst = 1'b0;
        step();

        // Back-to-back LSB traffic with a waiting fetch
        bus.lsb_req  = 1'b1;
        bus.lsb_addr = 32'h600;
        bus.lsb_len  = 4'd4;
        bus.ic_req   = 1'b1;
        bus.ic_addr  = 32'h700;
        for (int cyc = 0; cyc < 40 && grants.size() < 5; cyc++) begin
            bus.mc_lsb_done = bus.mc_r_en;
            bus.mc_lsb_data = 32'(cyc);
            bus.mc_ic_done  = bus.mc_ic_en;
            bus.mc_ic_data  = 32'h600D;
            step();
            if (bus.mc_r_en) begin
                grants.push_back(1);
`ifdef ARB_STARVE_GUARD_EN
                if (grants.size() == 4) chk_w("streak_saturated", 32'(dut.streak), 32'd4);
`endif
            end
            if (bus.mc_ic_en) begin
                grants.push_back(2);
`ifdef ARB_STARVE_GUARD_EN
                chk_w("streak_after_ic", 32'(dut.streak), 32'd0);
`endif
            end
        end
        if (grants.size() < 5) begin
            n_checks++;
            n_fail++;
            $display("FAIL starve_bound: got %0d grants expected 5", grants.size());
        end else begin
            for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_GUARD_EN
                exp_g = (g == 4) ? 2 : 1;
`else
                exp_g = 1;
`endif
                chk_w($sformatf("starve_grant_%0d", g), 32'(grants[g]), 32'(exp_g));
            end
        end

        // LSB backs off; the fetch must be served
        seen_ic     = 1'b0;
        bus.lsb_req = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.mc_ic_en) seen_ic = 1'b1;
            if (bus.ic_done) bus.ic_req = 1'b0;
            bus.mc_lsb_done = bus.mc_r_en;
            bus.mc_ic_done  = bus.mc_ic_en;
            step();
        end
        chk_b("ic_eventually_served", seen_ic, 1'b1);
        chk_w("final_idle", 32'(dut.state), 32'(ARB_Idle));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
